// File: rtl/tlb_unit.sv
// Joint TLB: entry array with TLBWI/TLBR/TLBP access for CP0, plus two independent
// single-cycle-latency address translators (fetch and data) with registered results.
module tlb_unit #(
  parameter  int TLB_ENTRIES_NUM = 16,
  localparam int IW              = $clog2(TLB_ENTRIES_NUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tlbrw_we,
  input  logic [IW-1:0] tlbrw_index,
  input  logic [77:0]   tlbrw_wdata,
  output logic [77:0]   tlbrw_rdata,
  input  logic [31:0]   tlbp_entry_hi,
  output logic [31:0]   tlbp_index,
  input  logic [7:0]    tlb_asid,
  input  logic          kseg0_uncached,
  input  logic          i_req,
  input  logic [31:0]   i_vaddr,
  input  logic          d_req,
  input  logic [31:0]   d_vaddr,
  input  logic          d_store,
  output logic          i_valid,
  output logic [31:0]   i_paddr,
  output logic          i_uncached,
  output logic          i_ex,
  output logic          i_refill,
  output logic [4:0]    i_exccode,
  output logic          d_valid,
  output logic [31:0]   d_paddr,
  output logic          d_uncached,
  output logic          d_ex,
  output logic          d_refill,
  output logic [4:0]    d_exccode
);

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  typedef struct packed {
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic [7:0]  asid;
    logic [18:0] vpn2;
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic        d0;
    logic        v0;
    logic        d1;
    logic        v1;
    logic        g;
  } entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        ex;
    logic        refill;
    logic [4:0]  exccode;
  } result_t;

  entry_t entry_q [TLB_ENTRIES_NUM];
  entry_t entry_d [TLB_ENTRIES_NUM];

  logic [TLB_ENTRIES_NUM-1:0] p_match;
  logic [TLB_ENTRIES_NUM-1:0] i_match;
  logic [TLB_ENTRIES_NUM-1:0] d_match;
  logic [IW:0]                p_sel;
  logic [IW:0]                i_sel;
  logic [IW:0]                d_sel;

  logic    i_valid_q, i_valid_d;
  logic    d_valid_q, d_valid_d;
  result_t i_res_q, i_res_d;
  result_t d_res_q, d_res_d;

  logic unused_entry_hi;
  assign unused_entry_hi = ^tlbp_entry_hi[12:8];

  function automatic logic key_hit(input entry_t e, input logic [18:0] vpn2,
                                   input logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  // {hit, index} of the lowest-numbered matching entry
  function automatic logic [IW:0] first_hit(input logic [TLB_ENTRIES_NUM-1:0] m);
    logic [IW:0] sel;
    sel = '0;
    for (int k = TLB_ENTRIES_NUM - 1; k >= 0; k--) begin
      if (m[k]) sel = {1'b1, IW'(k)};
    end
    return sel;
  endfunction

  function automatic result_t xlate(input logic [31:0] va, input logic store,
                                    input logic hit, input entry_t e,
                                    input logic kunc);
    result_t     r;
    logic        odd;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        v;
    logic        d;
    r   = '0;
    odd = va[12];
    pfn = odd ? e.pfn1 : e.pfn0;
    c   = odd ? e.c1   : e.c0;
    v   = odd ? e.v1   : e.v0;
    d   = odd ? e.d1   : e.d0;
    case (va[31:29])
      3'b100: begin
        r.paddr    = {3'b000, va[28:0]};
        r.uncached = kunc;
      end
      3'b101: begin
        r.paddr    = {3'b000, va[28:0]};
        r.uncached = 1'b1;
      end
      default: begin
        r.paddr    = {pfn, va[11:0]};
        r.uncached = (c == 3'd2);
        if (!hit) begin
          r.ex      = 1'b1;
          r.refill  = 1'b1;
          r.exccode = store ? EXC_TLBS : EXC_TLBL;
        end else if (!v) begin
          r.ex      = 1'b1;
          r.exccode = store ? EXC_TLBS : EXC_TLBL;
        end else if (store && !d) begin
          r.ex      = 1'b1;
          r.exccode = EXC_MOD;
        end
      end
    endcase
    return r;
  endfunction

  // Every consumer reads entry_q, so a same-cycle write is only seen next cycle
  always_comb begin
    entry_d = entry_q;
    if (tlbrw_we) entry_d[tlbrw_index] = entry_t'(tlbrw_wdata);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < TLB_ENTRIES_NUM; k++) begin
      entry_q[k] <= reset ? '0 : entry_d[k];
    end
  end

  for (genvar gi = 0; gi < TLB_ENTRIES_NUM; gi++) begin : g_match
    assign p_match[gi] = key_hit(entry_q[gi], tlbp_entry_hi[31:13], tlbp_entry_hi[7:0]);
    assign i_match[gi] = key_hit(entry_q[gi], i_vaddr[31:13], tlb_asid);
    assign d_match[gi] = key_hit(entry_q[gi], d_vaddr[31:13], tlb_asid);
  end

  assign p_sel = first_hit(p_match);
  assign i_sel = first_hit(i_match);
  assign d_sel = first_hit(d_match);

  assign tlbrw_rdata = entry_q[tlbrw_index];
  assign tlbp_index  = p_sel[IW] ? {{(32 - IW){1'b0}}, p_sel[IW-1:0]} : 32'h8000_0000;

  always_comb begin
    i_valid_d = i_req;
    d_valid_d = d_req;
    i_res_d   = i_res_q;
    d_res_d   = d_res_q;
    if (i_req) begin
      i_res_d = xlate(i_vaddr, 1'b0, i_sel[IW], entry_q[i_sel[IW-1:0]], kseg0_uncached);
    end
    if (d_req) begin
      d_res_d = xlate(d_vaddr, d_store, d_sel[IW], entry_q[d_sel[IW-1:0]], kseg0_uncached);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_res_q   <= '0;
      d_res_q   <= '0;
    end else begin
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_res_q   <= i_res_d;
      d_res_q   <= d_res_d;
    end
  end

  assign i_valid    = i_valid_q;
  assign i_paddr    = i_res_q.paddr;
  assign i_uncached = i_res_q.uncached;
  assign i_ex       = i_res_q.ex;
  assign i_refill   = i_res_q.refill;
  assign i_exccode  = i_res_q.exccode;

  assign d_valid    = d_valid_q;
  assign d_paddr    = d_res_q.paddr;
  assign d_uncached = d_res_q.uncached;
  assign d_ex       = d_res_q.ex;
  assign d_refill   = d_res_q.refill;
  assign d_exccode  = d_res_q.exccode;

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: directed vector table, hand-written corner sequences,
// then randomized traffic compared against an entry-list reference model.
module tb_tlb_unit;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        tlbrw_we;
  logic [3:0]  tlbrw_index;
  logic [77:0] tlbrw_wdata;
  logic [77:0] tlbrw_rdata;
  logic [31:0] tlbp_entry_hi;
  logic [31:0] tlbp_index;
  logic [7:0]  tlb_asid;
  logic        kseg0_uncached;
  logic        i_req, d_req, d_store;
  logic [31:0] i_vaddr, d_vaddr;
  logic        i_valid, i_uncached, i_ex, i_refill;
  logic        d_valid, d_uncached, d_ex, d_refill;
  logic [31:0] i_paddr, d_paddr;
  logic [4:0]  i_exccode, d_exccode;

  always #5 clk = ~clk;

  tlb_unit #(.TLB_ENTRIES_NUM(N)) dut (
    .clk(clk), .reset(reset),
    .tlbrw_we(tlbrw_we), .tlbrw_index(tlbrw_index), .tlbrw_wdata(tlbrw_wdata),
    .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .tlb_asid(tlb_asid), .kseg0_uncached(kseg0_uncached),
    .i_req(i_req), .i_vaddr(i_vaddr), .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store),
    .i_valid(i_valid), .i_paddr(i_paddr), .i_uncached(i_uncached), .i_ex(i_ex),
    .i_refill(i_refill), .i_exccode(i_exccode),
    .d_valid(d_valid), .d_paddr(d_paddr), .d_uncached(d_uncached), .d_ex(d_ex),
    .d_refill(d_refill), .d_exccode(d_exccode)
  );

  typedef struct {
    logic [2:0]  c0, c1;
    logic [7:0]  asid;
    logic [18:0] vpn2;
    logic [19:0] pfn0, pfn1;
    logic        d0, v0, d1, v1, g;
  } ent_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        unc;
    logic        ex;
    logic        refill;
    logic [4:0]  code;
    logic        chk_pa;   // paddr/uncached are meaningful only when some entry matched
  } res_t;

  typedef struct {
    logic [31:0] va;
    logic        st;
    logic [7:0]  asid;
    logic        kunc;
    res_t        exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  ent_t mdl [N];
  logic [18:0] vp_pool [3] = '{19'h00010, 19'h00011, 19'h60010};

  task automatic check(input string nm, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [77:0] pack(input ent_t e);
    return {e.c0, e.c1, e.asid, e.vpn2, e.pfn0, e.pfn1, e.d0, e.v0, e.d1, e.v1, e.g};
  endfunction

  function automatic int ref_match(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int e = 0; e < N; e++) begin
      if (mdl[e].vpn2 == vpn2 && (mdl[e].g || mdl[e].asid == asid)) return e;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ref_probe(input logic [31:0] hi);
    int e;
    e = ref_match(hi[31:13], hi[7:0]);
    return (e < 0) ? 32'h8000_0000 : 32'(e);
  endfunction

  function automatic res_t ref_xlate(input logic [31:0] va, input logic st,
                                     input logic [7:0] asid, input logic kunc);
    res_t r;
    int   e;
    ent_t m;
    logic v, d;
    r = '0;
    r.chk_pa = 1'b1;
    if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
      r.paddr = va & 32'h1FFF_FFFF;
      r.unc   = (va[31:29] == 3'b101) ? 1'b1 : kunc;
      return r;
    end
    e = ref_match(va[31:13], asid);
    if (e < 0) begin
      r.ex = 1'b1; r.refill = 1'b1; r.code = st ? 5'd3 : 5'd2; r.chk_pa = 1'b0;
      return r;
    end
    m = mdl[e];
    r.paddr = va[12] ? {m.pfn1, va[11:0]} : {m.pfn0, va[11:0]};
    r.unc   = ((va[12] ? m.c1 : m.c0) == 3'd2);
    v = va[12] ? m.v1 : m.v0;
    d = va[12] ? m.d1 : m.d0;
    if (!v) begin
      r.ex = 1'b1; r.code = st ? 5'd3 : 5'd2;
    end else if (st && !d) begin
      r.ex = 1'b1; r.code = 5'd1;
    end
    return r;
  endfunction

  task automatic chk_port(input string p, input logic av, input logic [31:0] pa,
                          input logic unc, input logic ex, input logic rf,
                          input logic [4:0] code, input logic ev, input res_t e);
    check({p, "_valid"},   78'(av),   78'(ev));
    check({p, "_ex"},      78'(ex),   78'(e.ex));
    check({p, "_refill"},  78'(rf),   78'(e.refill));
    check({p, "_exccode"}, 78'(code), 78'(e.code));
    if (e.chk_pa) begin
      check({p, "_paddr"},    78'(pa),  78'(e.paddr));
      check({p, "_uncached"}, 78'(unc), 78'(e.unc));
    end
  endtask

  task automatic chk_i(input logic ev, input res_t e);
    chk_port("i", i_valid, i_paddr, i_uncached, i_ex, i_refill, i_exccode, ev, e);
  endtask

  task automatic chk_d(input logic ev, input res_t e);
    chk_port("d", d_valid, d_paddr, d_uncached, d_ex, d_refill, d_exccode, ev, e);
  endtask

  task automatic wr(input int idx, input ent_t e);
    tlbrw_we    = 1'b1;
    tlbrw_index = 4'(idx);
    tlbrw_wdata = pack(e);
    tick();
    tlbrw_we    = 1'b0;
    mdl[idx]    = e;
    $display("write idx=%0d vpn2=%h asid=%h g=%0b", idx, e.vpn2, e.asid, e.g);
  endtask

  function automatic vec_t mkv(input logic [31:0] va, input logic st, input logic [7:0] asid,
                               input logic kunc, input logic [31:0] pa, input logic unc,
                               input logic ex, input logic rf, input logic [4:0] code,
                               input logic cpa);
    vec_t v;
    v.va = va; v.st = st; v.asid = asid; v.kunc = kunc;
    v.exp = '{paddr: pa, unc: unc, ex: ex, refill: rf, code: code, chk_pa: cpa};
    return v;
  endfunction

  function automatic ent_t zero_ent();
    ent_t e;
    e = '{c0: 3'd0, c1: 3'd0, asid: 8'd0, vpn2: 19'd0, pfn0: 20'd0, pfn1: 20'd0,
          d0: 1'b0, v0: 1'b0, d1: 1'b0, v1: 1'b0, g: 1'b0};
    return e;
  endfunction

  function automatic logic [31:0] gen_va();
    logic [31:0] r;
    int          s;
    r = $urandom();
    s = $urandom_range(0, 4);
    if (s == 0) return {3'b100, r[28:0]};
    if (s == 1) return {3'b101, r[28:0]};
    return {vp_pool[$urandom_range(0, 2)], r[12:0]};
  endfunction

  vec_t vecs [12];
  ent_t e3, ep, e4, er;
  res_t exp_i, exp_d, nxt_i, nxt_d, z;
  logic [31:0] r1, r2, r3;
  int   widx;
  logic wen;

  initial begin
    reset = 1'b1; tlbrw_we = 1'b0; tlbrw_index = '0; tlbrw_wdata = '0;
    tlbp_entry_hi = '0; tlb_asid = '0; kseg0_uncached = 1'b0;
    i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_store = 1'b0;
    for (int k = 0; k < N; k++) mdl[k] = zero_ent();
    z = '0;
    z.chk_pa = 1'b1;

    tick(); tick();
    chk_i(1'b0, z);
    chk_d(1'b0, z);
    check("reset_probe", 78'(tlbp_index), 78'(32'h0));
    tlbrw_index = 4'd5;
    #1 check("reset_rdata", tlbrw_rdata, 78'd0);
    reset = 1'b0;
    tick();

    e3 = '{c0: 3'd3, c1: 3'd2, asid: 8'h05, vpn2: 19'h00200, pfn0: 20'h01234,
           pfn1: 20'h05678, d0: 1'b1, v0: 1'b1, d1: 1'b0, v1: 1'b1, g: 1'b0};
    wr(3, e3);

    vecs[0]  = mkv(32'h0040_0ABC, 0, 8'h05, 0, 32'h0123_4ABC, 0, 0, 0, 5'd0, 1);
    vecs[1]  = mkv(32'h0040_0000, 0, 8'h06, 0, 32'h0,         0, 1, 1, 5'd2, 0);
    vecs[2]  = mkv(32'h0040_1000, 1, 8'h05, 0, 32'h0567_8000, 1, 1, 0, 5'd1, 1);
    vecs[3]  = mkv(32'h0040_1234, 0, 8'h05, 0, 32'h0567_8234, 1, 0, 0, 5'd0, 1);
    vecs[4]  = mkv(32'h0040_0010, 1, 8'h05, 0, 32'h0123_4010, 0, 0, 0, 5'd0, 1);
    vecs[5]  = mkv(32'hBFC0_0100, 0, 8'h00, 0, 32'h1FC0_0100, 1, 0, 0, 5'd0, 1);
    vecs[6]  = mkv(32'h8000_0040, 0, 8'h00, 0, 32'h0000_0040, 0, 0, 0, 5'd0, 1);
    vecs[7]  = mkv(32'h8000_0040, 1, 8'h00, 1, 32'h0000_0040, 1, 0, 0, 5'd0, 1);
    vecs[8]  = mkv(32'h0040_0000, 1, 8'h07, 0, 32'h0,         0, 1, 1, 5'd3, 0);
    vecs[9]  = mkv(32'h0000_0000, 0, 8'h00, 0, 32'h0000_0000, 0, 1, 0, 5'd2, 1);
    vecs[10] = mkv(32'hC000_0000, 0, 8'h05, 0, 32'h0,         0, 1, 1, 5'd2, 0);
    vecs[11] = mkv(32'h0040_0FFC, 1, 8'h05, 0, 32'h0123_4FFC, 0, 0, 0, 5'd0, 1);

    foreach (vecs[n]) begin
      d_req = 1'b1; d_vaddr = vecs[n].va; d_store = vecs[n].st;
      tlb_asid = vecs[n].asid; kseg0_uncached = vecs[n].kunc;
      i_req = ~vecs[n].st; i_vaddr = vecs[n].va;
      tick();
      d_req = 1'b0; i_req = 1'b0;
      $display("vec %0d va=%h st=%0b asid=%h -> d_paddr=%h d_ex=%0b code=%0d",
               n, vecs[n].va, vecs[n].st, vecs[n].asid, d_paddr, d_ex, d_exccode);
      chk_d(1'b1, vecs[n].exp);
      if (!vecs[n].st) chk_i(1'b1, vecs[n].exp);
      else check("i_valid_idle", 78'(i_valid), 78'd0);
    end

    // Global bit lets a foreign ASID hit
    e3.g = 1'b1;
    wr(3, e3);
    i_req = 1'b1; i_vaddr = 32'h0040_0000; tlb_asid = 8'h06;
    tick();
    i_req = 1'b0;
    $display("global lookup i_paddr=%h i_ex=%0b", i_paddr, i_ex);
    chk_i(1'b1, '{paddr: 32'h0123_4000, unc: 1'b0, ex: 1'b0, refill: 1'b0, code: 5'd0, chk_pa: 1'b1});

    // Invalid odd page on a store
    e3.v1 = 1'b0;
    wr(3, e3);
    d_req = 1'b1; d_vaddr = 32'h0040_1000; d_store = 1'b1; tlb_asid = 8'h05;
    tick();
    d_req = 1'b0; d_store = 1'b0;
    $display("invalid store d_exccode=%0d d_refill=%0b", d_exccode, d_refill);
    chk_d(1'b1, '{paddr: 32'h0567_8000, unc: 1'b1, ex: 1'b1, refill: 1'b0, code: 5'd3, chk_pa: 1'b1});

    // Duplicate entries: lowest index wins
    ep = '{c0: 3'd1, c1: 3'd1, asid: 8'h09, vpn2: 19'h12345, pfn0: 20'h11111,
           pfn1: 20'h22222, d0: 1'b1, v0: 1'b1, d1: 1'b1, v1: 1'b1, g: 1'b0};
    wr(2, ep);
    wr(7, ep);
    tlbp_entry_hi = {19'h12345, 5'h0, 8'h09};
    tlbrw_index = 4'd7;
    #1;
    $display("probe dup -> %h", tlbp_index);
    check("probe_dup", 78'(tlbp_index), 78'(32'd2));
    check("tlbr_idx7", tlbrw_rdata, pack(ep));
    tlbp_entry_hi = {19'h54321, 5'h0, 8'h09};
    #1 check("probe_miss", 78'(tlbp_index), 78'(32'h8000_0000));
    tlbp_entry_hi = {19'h12345, 5'h0, 8'h08};
    #1 check("probe_asid_miss", 78'(tlbp_index), 78'(32'h8000_0000));

    // Write and lookup/probe of the same key in one cycle see the old contents
    e4 = '{c0: 3'd3, c1: 3'd3, asid: 8'h01, vpn2: 19'h30000, pfn0: 20'hABCDE,
           pfn1: 20'h0, d0: 1'b1, v0: 1'b1, d1: 1'b0, v1: 1'b0, g: 1'b0};
    tlb_asid = 8'h01; tlbp_entry_hi = {19'h30000, 5'h0, 8'h01};
    d_req = 1'b1; d_vaddr = 32'h6000_0100; d_store = 1'b0;
    tlbrw_we = 1'b1; tlbrw_index = 4'd4; tlbrw_wdata = pack(e4);
    #1 check("probe_prewrite", 78'(tlbp_index), 78'(32'h8000_0000));
    tick();
    tlbrw_we = 1'b0; d_req = 1'b0; mdl[4] = e4;
    $display("same-cycle write: d_ex=%0b d_refill=%0b probe=%h", d_ex, d_refill, tlbp_index);
    chk_d(1'b1, '{paddr: 32'h0, unc: 1'b0, ex: 1'b1, refill: 1'b1, code: 5'd2, chk_pa: 1'b0});
    check("probe_postwrite", 78'(tlbp_index), 78'(32'd4));
    d_req = 1'b1;
    tick();
    d_req = 1'b0;
    chk_d(1'b1, '{paddr: 32'hABCD_E100, unc: 1'b0, ex: 1'b0, refill: 1'b0, code: 5'd0, chk_pa: 1'b1});

    // Reset with lookups in flight
    tlb_asid = 8'h05;
    i_req = 1'b1; i_vaddr = 32'h0040_0ABC;
    d_req = 1'b1; d_vaddr = 32'h0040_0ABC;
    tick();
    check("preflight_d_valid", 78'(d_valid), 78'd1);
    reset = 1'b1;
    tick();
    tlbp_entry_hi = 32'h0; tlbrw_index = 4'd3;
    #1;
    $display("after reset: i_valid=%0b d_valid=%0b d_paddr=%h", i_valid, d_valid, d_paddr);
    chk_i(1'b0, z);
    chk_d(1'b0, z);
    check("reset2_probe", 78'(tlbp_index), 78'(32'h0));
    check("reset2_rdata", tlbrw_rdata, 78'd0);
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < N; k++) mdl[k] = zero_ent();
    tick();

    // Randomized traffic against the reference model
    exp_i = z; exp_d = z;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
      wen  = (r1[31:30] == 2'b00);
      widx = $urandom_range(0, N - 1);
      er = '{c0: r1[2:0], c1: r1[5:3], asid: r1[6] ? 8'h02 : 8'h01,
             vpn2: vp_pool[$urandom_range(0, 2)], pfn0: r2[19:0], pfn1: r3[19:0],
             d0: r1[9], v0: r1[10] | r1[11], d1: r1[12], v1: r1[13] | r1[14],
             g: (r1[8:7] == 2'b00)};
      tlbrw_we = wen; tlbrw_index = 4'(widx); tlbrw_wdata = pack(er);
      i_req = r1[20]; i_vaddr = gen_va();
      d_req = r1[21]; d_vaddr = gen_va(); d_store = r1[22];
      tlb_asid = r1[23] ? 8'h02 : 8'h01;
      kseg0_uncached = r1[24];
      tlbp_entry_hi = {vp_pool[$urandom_range(0, 2)], 5'h0, r1[25] ? 8'h02 : 8'h01};
      nxt_i = i_req ? ref_xlate(i_vaddr, 1'b0, tlb_asid, kseg0_uncached) : exp_i;
      nxt_d = d_req ? ref_xlate(d_vaddr, d_store, tlb_asid, kseg0_uncached) : exp_d;
      #1;
      check("rand_probe", 78'(tlbp_index), 78'(ref_probe(tlbp_entry_hi)));
      check("rand_rdata", tlbrw_rdata, pack(mdl[widx]));
      tick();
      if (wen) mdl[widx] = er;
      exp_i = nxt_i; exp_d = nxt_d;
      $display("rand %0d: we=%0b idx=%0d i_req=%0b i_va=%h d_req=%0b d_va=%h st=%0b",
               cyc, wen, widx, i_req, i_vaddr, d_req, d_vaddr, d_store);
      chk_i(i_req, exp_i);
      chk_d(d_req, exp_d);
    end
    tlbrw_we = 1'b0; i_req = 1'b0; d_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
